// File: rtl/clz_pipe_norm_pkg.sv
// Shared types and elaboration-time helpers for the pipelined leading-run
// counter / normaliser.
package clz_pkg;

  typedef enum logic {
    CLZ_ZEROS = 1'b0,
    CLZ_ONES  = 1'b1
  } clz_mode_e;

  function automatic int unsigned clz_pow2(input int unsigned w);
    return 32'd1 << $clog2(w);
  endfunction

  // Earlier stages absorb the remainder when levels do not divide evenly.
  function automatic int unsigned clz_levels_in_stage(input int unsigned w,
                                                      input int unsigned n,
                                                      input int unsigned k);
    int unsigned lv;
    lv = $clog2(clz_pow2(w));
    return (lv / n) + ((k < (lv % n)) ? 32'd1 : 32'd0);
  endfunction

  function automatic int unsigned clz_first_level(input int unsigned w,
                                                  input int unsigned n,
                                                  input int unsigned k);
    int unsigned acc;
    acc = 0;
    for (int unsigned i = 0; i < k; i++) begin
      acc += clz_levels_in_stage(w, n, i);
    end
    return acc;
  endfunction

endpackage

// File: rtl/clz_pipe_norm_if.sv
// Input/output stream bundle for clz_pipe_norm; master drives words in and
// consumes results, slave is the pipeline itself.
interface clz_pipe_norm_if #(
  parameter int unsigned W_IN  = 32,
  parameter int unsigned W_OUT = $clog2(W_IN + 1)
);
  logic             in_valid;
  logic             in_ready;
  logic [W_IN-1:0]  in_data;
  logic             in_mode;
  logic             out_valid;
  logic             out_ready;
  logic [W_OUT-1:0] out_count;
  logic             out_all;
  logic [W_IN-1:0]  out_norm;
  logic             out_mode;

  modport master (
    output in_valid, in_data, in_mode, out_ready,
    input  in_ready, out_valid, out_count, out_all, out_norm, out_mode
  );

  modport slave (
    input  in_valid, in_data, in_mode, out_ready,
    output in_ready, out_valid, out_count, out_all, out_norm, out_mode
  );
endinterface

// File: rtl/clz_pipe_norm_stage.sv
// One pipeline stage: resolves its share of binary-split tree levels and,
// when it is the last stage, performs the normalising left shift.
module clz_pipe_stage
  import clz_pkg::*;
#(
  parameter int unsigned W_IN  = 32,
  parameter int unsigned P     = 32,
  parameter int unsigned L     = 5,
  parameter int unsigned FIRST = 0,
  parameter int unsigned NLEV  = 1,
  parameter bit          LAST  = 1'b0
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            in_valid,
  input  logic [W_IN-1:0] in_data,
  input  clz_mode_e       in_mode,
  input  logic [L-1:0]    in_cnt,
  input  logic [P-1:0]    in_win,
  input  logic            load_next,
  output logic            load,
  output logic            valid_q,
  output logic [W_IN-1:0] data_q,
  output clz_mode_e       mode_q,
  output logic [L-1:0]    cnt_q,
  output logic [P-1:0]    win_q
);

  logic            valid_d;
  logic [W_IN-1:0] data_d;
  clz_mode_e       mode_d;
  logic [L-1:0]    cnt_d;
  logic [P-1:0]    win_d;

  logic [P-1:0]    win_v;
  logic [P-1:0]    mask;
  logic [L-1:0]    cnt_v;
  logic [W_IN-1:0] data_v;
  logic            upper_zero;
  int unsigned     h;

  assign load = ~valid_q | load_next;

  always_comb begin
    win_v      = in_win;
    cnt_v      = in_cnt;
    mask       = '0;
    upper_zero = 1'b0;
    h          = 0;
    // Window stays right-aligned; level j halves it from P>>j to P>>(j+1).
    for (int unsigned j = FIRST; j < FIRST + NLEV; j++) begin
      h          = P >> (j + 1);
      mask       = (P'(1) << h) - P'(1);
      upper_zero = ((win_v >> h) & mask) == '0;
      cnt_v      = cnt_v | (L'(upper_zero) << (L - 1 - j));
      win_v      = upper_zero ? (win_v & mask) : ((win_v >> h) & mask);
    end

    if (LAST) begin
      data_v = (~|win_v) ? '0 : (in_data << cnt_v);
    end else begin
      data_v = in_data;
    end

    valid_d = load ? in_valid : valid_q;
    data_d  = load ? data_v   : data_q;
    mode_d  = load ? in_mode  : mode_q;
    cnt_d   = load ? cnt_v    : cnt_q;
    win_d   = load ? win_v    : win_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q <= 1'b0;
      data_q  <= '0;
      mode_q  <= CLZ_ZEROS;
      cnt_q   <= '0;
      win_q   <= '0;
    end else begin
      valid_q <= valid_d;
      data_q  <= data_d;
      mode_q  <= mode_d;
      cnt_q   <= cnt_d;
      win_q   <= win_d;
    end
  end

endmodule

// File: rtl/clz_pipe_norm.sv
// Pipelined leading-zero/leading-one counter and normaliser with valid/ready
// handshakes and bubble-collapsing stages.
module clz_pipe_norm
  import clz_pkg::*;
#(
  parameter int unsigned W_IN     = 32,
  parameter int unsigned W_OUT    = $clog2(W_IN + 1),
  parameter int unsigned N_STAGES = 2
) (
  input logic            clk,
  input logic            rst_n,
  clz_pipe_norm_if.slave bus
);

  localparam int unsigned P = clz_pow2(W_IN);
  localparam int unsigned L = $clog2(P);

  logic [N_STAGES:0]            v;
  logic [N_STAGES:0]            ld;
  logic [N_STAGES:0][W_IN-1:0]  dat;
  logic [N_STAGES:0][L-1:0]     cnt;
  logic [N_STAGES:0][P-1:0]     win;
  clz_mode_e                    md [N_STAGES+1];

  logic [W_IN-1:0] scan;
  logic            out_all_w;

  assign md[0]  = clz_mode_e'(bus.in_mode);
  assign scan   = (md[0] == CLZ_ONES) ? ~bus.in_data : bus.in_data;
  assign v[0]   = bus.in_valid;
  assign dat[0] = bus.in_data;
  assign cnt[0] = '0;
  // Zero padding at the LSB end keeps leading-run positions unchanged.
  assign win[0] = P'(scan) << (P - W_IN);

  assign ld[N_STAGES] = ~v[N_STAGES] | bus.out_ready;
  assign bus.in_ready = ld[0];

  for (genvar k = 0; k < N_STAGES; k++) begin : g_stage
    clz_pipe_stage #(
      .W_IN (W_IN),
      .P    (P),
      .L    (L),
      .FIRST(clz_first_level(W_IN, N_STAGES, k)),
      .NLEV (clz_levels_in_stage(W_IN, N_STAGES, k)),
      .LAST (k == N_STAGES - 1)
    ) u_stage (
      .clk      (clk),
      .rst_n    (rst_n),
      .in_valid (v[k]),
      .in_data  (dat[k]),
      .in_mode  (md[k]),
      .in_cnt   (cnt[k]),
      .in_win   (win[k]),
      .load_next(ld[k+1]),
      .load     (ld[k]),
      .valid_q  (v[k+1]),
      .data_q   (dat[k+1]),
      .mode_q   (md[k+1]),
      .cnt_q    (cnt[k+1]),
      .win_q    (win[k+1])
    );
  end

  // An empty final window means the scanned word had no set bit at all.
  assign out_all_w     = v[N_STAGES] & ~|win[N_STAGES];
  assign bus.out_valid = v[N_STAGES];
  assign bus.out_all   = out_all_w;
  assign bus.out_count = out_all_w ? W_OUT'(W_IN) : W_OUT'(cnt[N_STAGES]);
  assign bus.out_norm  = dat[N_STAGES];
  assign bus.out_mode  = (md[N_STAGES] == CLZ_ONES);

endmodule

// File: tb/tb_clz_pipe_norm.sv
// Directed bench for clz_pipe_norm at W_IN=12, N_STAGES=2.
module tb_clz_pipe_norm;

  typedef struct packed {
    logic [11:0] d;
    logic        m;
    logic [3:0]  c;
    logic        a;
    logic [11:0] n;
  } vec_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   total = 0;
  int   bad = 0;

  always #5 clk = ~clk;

  clz_pipe_norm_if #(.W_IN(12), .W_OUT(4)) bus ();

  clz_pipe_norm #(.W_IN(12), .W_OUT(4), .N_STAGES(2)) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  function automatic vec_t ref_model(input logic [11:0] d, input logic m);
    vec_t        r;
    logic [11:0] s;
    int          cz;
    bit          found;
    s = m ? ~d : d;
    cz = 0;
    found = 0;
    for (int i = 11; i >= 0; i--) begin
      if (!found && !s[i]) cz++;
      else found = 1;
    end
    r.d = d;
    r.m = m;
    r.c = 4'(cz);
    r.a = (cz == 12);
    r.n = (cz == 12) ? 12'h000 : (d << cz);
    return r;
  endfunction

  task automatic run_one(input logic [11:0] d, input logic m,
                         output logic [3:0] c, output logic a,
                         output logic [11:0] n, output logic om, output int lat);
    @(negedge clk);
    bus.in_valid = 1'b1;
    bus.in_data = d;
    bus.in_mode = m;
    bus.out_ready = 1'b1;
    @(negedge clk);
    bus.in_valid = 1'b0;
    lat = 1;
    while (!bus.out_valid && lat < 20) begin
      @(negedge clk);
      lat++;
    end
    c = bus.out_count;
    a = bus.out_all;
    n = bus.out_norm;
    om = bus.out_mode;
  endtask

  task automatic test_reset;
    bus.in_valid = 1'b0;
    bus.in_data = '0;
    bus.in_mode = 1'b0;
    bus.out_ready = 1'b0;
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    total++; if (bus.out_valid !== 1'b0) begin bad++; $display("FAIL reset_valid got=%b exp=0", bus.out_valid); end
    total++; if (bus.out_count !== 4'd0) begin bad++; $display("FAIL reset_count got=%0d exp=0", bus.out_count); end
    total++; if (bus.out_all !== 1'b0) begin bad++; $display("FAIL reset_all got=%b exp=0", bus.out_all); end
    total++; if (bus.out_norm !== 12'h000) begin bad++; $display("FAIL reset_norm got=%h exp=000", bus.out_norm); end
    total++; if (bus.out_mode !== 1'b0) begin bad++; $display("FAIL reset_mode got=%b exp=0", bus.out_mode); end
    rst_n = 1'b1;
    @(negedge clk);
    #1;
    total++; if (bus.in_ready !== 1'b1) begin bad++; $display("FAIL reset_in_ready got=%b exp=1", bus.in_ready); end
  endtask

  task automatic test_zeros;
    logic [3:0] c; logic a; logic [11:0] n; logic om; int lat;
    run_one(12'h0F0, 1'b0, c, a, n, om, lat);
    total++; if (lat != 2) begin bad++; $display("FAIL zeros_latency got=%0d exp=2", lat); end
    total++; if (c !== 4'd4) begin bad++; $display("FAIL zeros_count got=%0d exp=4", c); end
    total++; if (a !== 1'b0) begin bad++; $display("FAIL zeros_all got=%b exp=0", a); end
    total++; if (n !== 12'hF00) begin bad++; $display("FAIL zeros_norm got=%h exp=f00", n); end
    total++; if (om !== 1'b0) begin bad++; $display("FAIL zeros_mode got=%b exp=0", om); end
  endtask

  task automatic test_all_zero;
    logic [3:0] c; logic a; logic [11:0] n; logic om; int lat;
    run_one(12'h000, 1'b0, c, a, n, om, lat);
    total++; if (c !== 4'd12) begin bad++; $display("FAIL allz_count got=%0d exp=12", c); end
    total++; if (a !== 1'b1) begin bad++; $display("FAIL allz_all got=%b exp=1", a); end
    total++; if (n !== 12'h000) begin bad++; $display("FAIL allz_norm got=%h exp=000", n); end
    run_one(12'hFFF, 1'b1, c, a, n, om, lat);
    total++; if (c !== 4'd12) begin bad++; $display("FAIL allo_count got=%0d exp=12", c); end
    total++; if (a !== 1'b1) begin bad++; $display("FAIL allo_all got=%b exp=1", a); end
    total++; if (n !== 12'h000) begin bad++; $display("FAIL allo_norm got=%h exp=000", n); end
    total++; if (om !== 1'b1) begin bad++; $display("FAIL allo_mode got=%b exp=1", om); end
  endtask

  task automatic test_ones;
    logic [3:0] c; logic a; logic [11:0] n; logic om; int lat;
    run_one(12'hE12, 1'b1, c, a, n, om, lat);
    total++; if (c !== 4'd3) begin bad++; $display("FAIL ones_count got=%0d exp=3", c); end
    total++; if (a !== 1'b0) begin bad++; $display("FAIL ones_all got=%b exp=0", a); end
    total++; if (n !== 12'h090) begin bad++; $display("FAIL ones_norm got=%h exp=090", n); end
    total++; if (om !== 1'b1) begin bad++; $display("FAIL ones_mode got=%b exp=1", om); end
    run_one(12'h800, 1'b0, c, a, n, om, lat);
    total++; if (c !== 4'd0) begin bad++; $display("FAIL msb_count got=%0d exp=0", c); end
    total++; if (n !== 12'h800) begin bad++; $display("FAIL msb_norm got=%h exp=800", n); end
    total++; if (om !== 1'b0) begin bad++; $display("FAIL msb_mode got=%b exp=0", om); end
  endtask

  task automatic test_back_pressure;
    vec_t tbl [6];
    vec_t exp_q[$];
    vec_t e;
    logic prev_stall;
    logic [3:0] pc; logic pa; logic [11:0] pn; logic pm;
    int idx, n_out, acc_early;
    tbl[0] = '{d: 12'h001, m: 1'b0, c: 4'd11, a: 1'b0, n: 12'h800};
    tbl[1] = '{d: 12'hFD3, m: 1'b1, c: 4'd6,  a: 1'b0, n: 12'h4C0};
    tbl[2] = '{d: 12'h3A5, m: 1'b0, c: 4'd2,  a: 1'b0, n: 12'hE94};
    tbl[3] = '{d: 12'h000, m: 1'b1, c: 4'd0,  a: 1'b0, n: 12'h000};
    tbl[4] = '{d: 12'hFFF, m: 1'b0, c: 4'd0,  a: 1'b0, n: 12'hFFF};
    tbl[5] = '{d: 12'h040, m: 1'b0, c: 4'd5,  a: 1'b0, n: 12'h800};
    idx = 0; n_out = 0; acc_early = 0; prev_stall = 1'b0;
    pc = '0; pa = 1'b0; pn = '0; pm = 1'b0;
    for (int t = 0; t < 20; t++) begin
      @(negedge clk);
      bus.out_ready = (t >= 4);
      #1;
      if (prev_stall) begin
        total++;
        if (bus.out_valid !== 1'b1 || bus.out_count !== pc || bus.out_all !== pa ||
            bus.out_norm !== pn || bus.out_mode !== pm) begin
          bad++;
          $display("FAIL bp_stable t=%0d got v=%b c=%0d n=%h exp v=1 c=%0d n=%h",
                   t, bus.out_valid, bus.out_count, bus.out_norm, pc, pn);
        end
      end
      if (bus.out_valid && bus.out_ready) begin
        if (exp_q.size() == 0) begin
          total++; bad++;
          $display("FAIL bp_extra t=%0d got c=%0d n=%h exp none", t, bus.out_count, bus.out_norm);
        end else begin
          e = exp_q.pop_front();
          total++;
          if (bus.out_count !== e.c || bus.out_all !== e.a || bus.out_norm !== e.n || bus.out_mode !== e.m) begin
            bad++;
            $display("FAIL bp_result #%0d got c=%0d a=%b n=%h m=%b exp c=%0d a=%b n=%h m=%b",
                     n_out, bus.out_count, bus.out_all, bus.out_norm, bus.out_mode, e.c, e.a, e.n, e.m);
          end
        end
        n_out++;
      end
      prev_stall = bus.out_valid && !bus.out_ready;
      pc = bus.out_count; pa = bus.out_all; pn = bus.out_norm; pm = bus.out_mode;
      if (idx < 6) begin
        bus.in_valid = 1'b1;
        bus.in_data = tbl[idx].d;
        bus.in_mode = tbl[idx].m;
        if (bus.in_ready) begin
          exp_q.push_back(tbl[idx]);
          idx++;
          if (t < 4) acc_early++;
        end
      end else begin
        bus.in_valid = 1'b0;
      end
    end
    total++; if (acc_early != 2) begin bad++; $display("FAIL bp_capacity got=%0d exp=2", acc_early); end
    total++; if (n_out != 6) begin bad++; $display("FAIL bp_count got=%0d exp=6", n_out); end
  endtask

  task automatic test_throughput;
    vec_t exp_q[$];
    vec_t e;
    int n_out, first, gaps;
    n_out = 0; first = -1; gaps = 0;
    bus.out_ready = 1'b1;
    for (int t = 0; t < 24; t++) begin
      @(negedge clk);
      #1;
      if (bus.out_valid) begin
        if (first < 0) first = t;
        if (t != first + n_out) gaps++;
        if (exp_q.size() == 0) begin
          total++; bad++;
          $display("FAIL tp_extra t=%0d got n=%h exp none", t, bus.out_norm);
        end else begin
          e = exp_q.pop_front();
          total++;
          if (bus.out_count !== e.c || bus.out_all !== e.a || bus.out_norm !== e.n || bus.out_mode !== e.m) begin
            bad++;
            $display("FAIL tp_result #%0d d=%h got c=%0d a=%b n=%h m=%b exp c=%0d a=%b n=%h m=%b",
                     n_out, e.d, bus.out_count, bus.out_all, bus.out_norm, bus.out_mode, e.c, e.a, e.n, e.m);
          end
        end
        n_out++;
      end
      if (t < 16) begin
        e = ref_model(12'($urandom), 1'($urandom_range(0, 1)));
        bus.in_valid = 1'b1;
        bus.in_data = e.d;
        bus.in_mode = e.m;
        total++;
        if (bus.in_ready !== 1'b1) begin
          bad++;
          $display("FAIL tp_in_ready t=%0d got=%b exp=1", t, bus.in_ready);
        end else begin
          exp_q.push_back(e);
        end
      end else begin
        bus.in_valid = 1'b0;
      end
    end
    total++; if (first != 2) begin bad++; $display("FAIL tp_first got=%0d exp=2", first); end
    total++; if (gaps != 0) begin bad++; $display("FAIL tp_gaps got=%0d exp=0", gaps); end
    total++; if (n_out != 16) begin bad++; $display("FAIL tp_count got=%0d exp=16", n_out); end
  endtask

  task automatic test_reset_midstream;
    logic [3:0] c; logic a; logic [11:0] n; logic om; int lat;
    logic stale;
    @(negedge clk);
    bus.out_ready = 1'b0;
    bus.in_valid = 1'b1;
    bus.in_data = 12'h123;
    bus.in_mode = 1'b0;
    @(negedge clk);
    bus.in_data = 12'h456;
    @(negedge clk);
    bus.in_valid = 1'b0;
    #1;
    total++; if (bus.out_valid !== 1'b1) begin bad++; $display("FAIL mid_inflight got=%b exp=1", bus.out_valid); end
    #2;
    rst_n = 1'b0;
    #1;
    total++; if (bus.out_valid !== 1'b0) begin bad++; $display("FAIL mid_async_valid got=%b exp=0", bus.out_valid); end
    total++; if (bus.out_norm !== 12'h000) begin bad++; $display("FAIL mid_async_norm got=%h exp=000", bus.out_norm); end
    total++; if (bus.out_count !== 4'd0) begin bad++; $display("FAIL mid_async_count got=%0d exp=0", bus.out_count); end
    @(negedge clk);
    rst_n = 1'b1;
    bus.out_ready = 1'b1;
    stale = 1'b0;
    repeat (6) begin
      @(negedge clk);
      #1;
      if (bus.out_valid) stale = 1'b1;
    end
    total++; if (stale !== 1'b0) begin bad++; $display("FAIL mid_stale got=%b exp=0", stale); end
    run_one(12'h0A5, 1'b0, c, a, n, om, lat);
    total++; if (lat != 2) begin bad++; $display("FAIL mid_latency got=%0d exp=2", lat); end
    total++; if (c !== 4'd4) begin bad++; $display("FAIL mid_count got=%0d exp=4", c); end
    total++; if (n !== 12'hA50) begin bad++; $display("FAIL mid_norm got=%h exp=a50", n); end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    test_reset();
    test_zeros();
    test_all_zero();
    test_ones();
    test_back_pressure();
    test_throughput();
    test_reset_midstream();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/clz_pipe_norm.md
# clz_pipe_norm

Pipelined, parametrised leading-zero/leading-one counter and normaliser for the decoder datapath. Each accepted word yields the count of leading zeros or leading ones, according to a per-word mode bit. It also yields the word left-shifted by that count, so the first differing bit lands at the MSB. Valid/ready handshakes on both sides let it sit between the bitstream aligner and the prefix/remainder split logic at one word per cycle.

## Interface
- W_IN, 32: input word width, any value ≥ 2 (need not be a power of two)
- W_OUT, $clog2(W_IN+1): count width; must be ≥ $clog2(W_IN+1)
- N_STAGES, 2: register stages from input to output, 1 ≤ N_STAGES ≤ $clog2(W_IN)+1
- clk  in  1  clock
- rst_n  in  1  reset; one clock, asynchronous, active-low
- in_valid  in  1  input word present
- in_ready  out  1  block accepts input this cycle
- in_data  in  W_IN  word to scan, MSB first
- in_mode  in  1  0: count leading zeros; 1: count leading ones
- out_valid  out  1  result present
- out_ready  in  1  consumer accepts result
- out_count  out  W_OUT  leading run length, 0..W_IN
- out_all  out  1  entire word equals the run bit (count = W_IN)
- out_norm  out  W_IN  in_data << out_count, zero-filled
- out_mode  out  1  in_mode carried with the word

## Operation
- Internally scan s = in_mode ? ~in_data : in_data; count leading zeros of s.
- Pad s at the LSB end with zeros to P = 2^$clog2(W_IN). Binary-split tree: at each level, test whether the upper half is all-zero, emit one count bit, and select a half.
- All-zero s forces out_count = W_IN and out_all = 1. Otherwise out_all = 0 and out_count < W_IN.
- out_norm shifts the original in_data, not s. When out_all = 1, out_norm = 0.
- Tree levels are split across N_STAGES as evenly as possible, earlier stages taking the extra level. The normalising shift occupies the final stage.
- Each stage has a valid bit and advances independently, with bubble collapse. Stage k loads when it is empty or stage k+1 loads that cycle. The last stage loads when out_valid = 0 or out_ready = 1.
- in_ready = stage-0 load condition. The ready chain is combinational across stages.
- Words leave in acceptance order, never dropped or duplicated.

## Timing
- Latency is N_STAGES cycles from in_valid & in_ready to out_valid when unstalled.
- Throughput is 1 word/cycle while out_ready = 1.
- Capacity is N_STAGES words. With out_ready held low, in_ready falls after N_STAGES accepts.
- Outputs hold stable while out_valid & ~out_ready.
- Simultaneous accept and emit in the same cycle is legal with a full pipeline. No bubble is inserted.
- Reset: rst_n low clears every stage valid, data, count and mode register immediately (asynchronous). out_valid, out_count, out_all, out_norm and out_mode are 0. in_ready is 1 in the first cycle after rst_n rises.
- Reset mid-stream discards every in-flight word. None appears after release.
- in_ready depends on out_ready combinationally. in_ready does not depend on in_valid.

## Structure
- Package clz_pkg:
  - typedef enum logic {CLZ_ZEROS, CLZ_ONES} clz_mode_e
  - function clz_pow2(w) returning the padded width P
  - function clz_levels_in_stage(w, n, k) giving the tree-level partition
- Sub-module clz_pipe_stage: one register stage. Holds valid, the partially-resolved count bits, the remaining sub-word window, the original data and the mode; applies its allotted tree levels. Instantiated N_STAGES times via generate. The final instance also performs the shift.
- Top-level scope is padding, inversion, the all-zero override, and handshake wiring.

## Test plan
All scenarios use W_IN=12, N_STAGES=2.
- Zeros mode: in_data=12'h0F0, mode 0 → two cycles later count=4, all=0, norm=12'hF00.
- All-zero word: in_data=12'h000, mode 0 → count=12, all=1, norm=12'h000. Ones mode on 12'hFFF → count=12, all=1, norm=0.
- Ones mode: in_data=12'hE12, mode 1 → count=3, norm=12'h090, out_mode=1. Then 12'h800 mode 0 → count=0, norm=12'h800.
- Back-pressure: stream 6 words, hold out_ready=0 for 4 cycles → in_ready drops after 2 accepts. All 6 results emerge in order, with no loss or duplication, and outputs stay stable during the stall.
- Throughput: 16 random words with in_valid and out_ready held high → 16 consecutive out_valid cycles starting at cycle 2. Each result matches the reference model.
- Reset mid-stream: drop rst_n with 2 words in flight → out_valid=0 without waiting for a clock edge. After release, no stale result appears, and the next word returns correctly 2 cycles after acceptance.
